// File: rtl/riscv_pkg.sv
// riscv_pkg: RV64I opcode, funct3, CSR address and writeback FSM constants
package riscv_pkg;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_OP     = 7'h33;
   localparam logic [6:0] OP_IMM32  = 7'h1B;
   localparam logic [6:0] OP_32     = 7'h3B;
   localparam logic [6:0] OP_SYSTEM = 7'h73;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [1:0] CSR_RW = 2'b01;
   localparam logic [1:0] CSR_RS = 2'b10;
   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [31:0] ECALL_INSN = 32'h0000_0073;
   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_TRAP_EPC   = 2'd1;
   localparam logic [1:0] ST_TRAP_CAUSE = 2'd2;
   localparam logic [1:0] ST_TRAP_JUMP  = 2'd3;
endpackage

// File: rtl/load_align.sv
// load_align: select the addressed byte/half/word of a dcache doubleword and extend it
module load_align
   import riscv_pkg::*;
(
   input  logic        en,
   input  logic [2:0]  funct3,
   input  logic [2:0]  offset,
   input  logic [63:0] rdata,
   output logic [63:0] result
);
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] w;
   assign b = 8'(rdata >> {offset, 3'b000});
   assign h = 16'(rdata >> {offset[2:1], 4'b0000});
   assign w = 32'(rdata >> {offset[2], 5'b00000});
   assign result = !en               ? '0 :
                   funct3 == F3_LB  ? {{56{b[7]}}, b} :
                   funct3 == F3_LH  ? {{48{h[15]}}, h} :
                   funct3 == F3_LW  ? {{32{w[31]}}, w} :
                   funct3 == F3_LD  ? rdata :
                   funct3 == F3_LBU ? {56'b0, b} :
                   funct3 == F3_LHU ? {48'b0, h} :
                   funct3 == F3_LWU ? {32'b0, w} : '0;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: RV64I write-back latch, register/CSR commit and ECALL trap sequencing
module writeback_stage
   import riscv_pkg::*;
#(
   parameter int                XLEN        = 64,
   parameter logic [XLEN-1:0]   ECALL_CAUSE = 64'd11
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ld_wb,
   input  logic            mem_v,
   input  logic [31:0]     mem_ir,
   input  logic [XLEN-1:0] mem_npc,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [XLEN-1:0] mem_csrfd,
   input  logic [XLEN-1:0] mem_rs1,
   input  logic [XLEN-1:0] mtvec,
   output logic            wb_v,
   output logic [31:0]     wb_ir,
   output logic [XLEN-1:0] wb_alu_result,
   output logic [XLEN-1:0] wb_mem_result,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_ld_reg,
   output logic            wb_st_csr,
   output logic [11:0]     wb_csr_addr,
   output logic [XLEN-1:0] wb_csr_data,
   output logic            wb_cs,
   output logic            wb_cause,
   output logic            wb_stall,
   output logic            wb_redirect,
   output logic [XLEN-1:0] wb_redirect_pc
);
   logic [1:0]      state;
   logic [XLEN-1:0] wb_npc, wb_rdata, wb_csrfd, wb_rs1, src, csr_new;
   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [4:0]      rd, uimm;
   logic            run, is_ecall, writes_rd, csr_we;
   assign opcode   = wb_ir[6:0];
   assign f3       = wb_ir[14:12];
   assign rd       = wb_ir[11:7];
   assign uimm     = wb_ir[19:15];
   assign run      = state == ST_RUN;
   assign is_ecall = wb_v && wb_ir == ECALL_INSN;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= ST_RUN;
         wb_v          <= 1'b0;
         wb_ir         <= '0;
         wb_npc        <= '0;
         wb_alu_result <= '0;
         wb_rdata      <= '0;
         wb_csrfd      <= '0;
         wb_rs1        <= '0;
      end else begin
         state <= run ? (is_ecall ? ST_TRAP_EPC : ST_RUN) :
                  state == ST_TRAP_EPC ? ST_TRAP_CAUSE :
                  state == ST_TRAP_CAUSE ? ST_TRAP_JUMP : ST_RUN;
         if (ld_wb && !wb_stall) begin
            wb_v          <= mem_v;
            wb_ir         <= mem_ir;
            wb_npc        <= mem_npc;
            wb_alu_result <= mem_alu_result;
            wb_rdata      <= mem_rdata;
            wb_csrfd      <= mem_csrfd;
            wb_rs1        <= mem_rs1;
         end
         // the instruction behind the ECALL is killed as the redirect goes out
         if (state == ST_TRAP_JUMP) wb_v <= 1'b0;
      end
   load_align u_load_align (
      .en     (opcode == OP_LOAD),
      .funct3 (f3),
      .offset (wb_alu_result[2:0]),
      .rdata  (wb_rdata),
      .result (wb_mem_result)
   );
   assign writes_rd = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
                                     OP_IMM, OP_OP, OP_IMM32, OP_32} ||
                      (opcode == OP_SYSTEM && f3 != 3'b000);
   assign wb_ld_reg = run && wb_v && rd != 5'd0 && writes_rd;
   assign wb_data   = opcode == OP_LOAD ? wb_mem_result :
                      (opcode == OP_JAL || opcode == OP_JALR) ? wb_npc :
                      opcode == OP_SYSTEM ? wb_csrfd : wb_alu_result;
   assign src     = f3[2] ? {{(XLEN-5){1'b0}}, uimm} : wb_rs1;
   assign csr_new = f3[1:0] == CSR_RW ? src :
                    f3[1:0] == CSR_RS ? (wb_csrfd | src) : (wb_csrfd & ~src);
   // set/clear forms with a zero source are pure reads
   assign csr_we = run && wb_v && opcode == OP_SYSTEM && f3[1:0] != 2'b00 &&
                   (f3[1:0] == CSR_RW || uimm != 5'd0);
   assign wb_st_csr   = csr_we || state == ST_TRAP_EPC || state == ST_TRAP_CAUSE;
   assign wb_csr_addr = state == ST_TRAP_EPC ? CSR_MEPC :
                        state == ST_TRAP_CAUSE ? CSR_MCAUSE : wb_ir[31:20];
   assign wb_csr_data = state == ST_TRAP_EPC ? wb_npc - XLEN'(4) :
                        state == ST_TRAP_CAUSE ? ECALL_CAUSE : csr_new;
   assign wb_cs          = !run;
   assign wb_cause       = state == ST_TRAP_CAUSE;
   assign wb_redirect    = state == ST_TRAP_JUMP;
   assign wb_stall       = (run && is_ecall) || state == ST_TRAP_EPC || state == ST_TRAP_CAUSE;
   assign wb_redirect_pc = mtvec & ~XLEN'(3);
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: vector table, randomized model comparison and trap/reset sequences
module tb_writeback_stage;
   logic        clk = 1'b0, rst_n = 1'b0, ld_wb = 1'b0, mem_v = 1'b0;
   logic [31:0] mem_ir = '0;
   logic [63:0] mem_npc = '0, mem_alu_result = '0, mem_rdata = '0, mem_csrfd = '0, mem_rs1 = '0;
   logic [63:0] mtvec = 64'h8003;
   logic        wb_v, wb_ld_reg, wb_st_csr, wb_cs, wb_cause, wb_stall, wb_redirect;
   logic [31:0] wb_ir;
   logic [11:0] wb_csr_addr;
   logic [63:0] wb_alu_result, wb_mem_result, wb_data, wb_csr_data, wb_redirect_pc;
   int checks = 0, passed = 0;

   writeback_stage dut (
      .clk(clk), .rst_n(rst_n), .ld_wb(ld_wb), .mem_v(mem_v), .mem_ir(mem_ir),
      .mem_npc(mem_npc), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
      .mem_csrfd(mem_csrfd), .mem_rs1(mem_rs1), .mtvec(mtvec), .wb_v(wb_v), .wb_ir(wb_ir),
      .wb_alu_result(wb_alu_result), .wb_mem_result(wb_mem_result), .wb_data(wb_data),
      .wb_ld_reg(wb_ld_reg), .wb_st_csr(wb_st_csr), .wb_csr_addr(wb_csr_addr),
      .wb_csr_data(wb_csr_data), .wb_cs(wb_cs), .wb_cause(wb_cause), .wb_stall(wb_stall),
      .wb_redirect(wb_redirect), .wb_redirect_pc(wb_redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
      return {imm, rs1, f3, rd, op};
   endfunction

   // reference: architectural effect of one instruction in write-back
   task automatic model(input logic [31:0] ir, input logic v, input logic [63:0] npc,
                        input logic [63:0] alu, input logic [63:0] rdata,
                        input logic [63:0] old, input logic [63:0] rs1v,
                        output logic [63:0] data, output logic ld, output logic st,
                        output logic [11:0] addr, output logic [63:0] cdata,
                        output logic [63:0] memres);
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [63:0] sh, srcv;
      int          idx, kind;
      op = ir[6:0];
      f3 = ir[14:12];
      idx = int'(alu % 8);
      memres = 0;
      if (op == 7'h03) begin
         case (f3)
            3'd0, 3'd4: sh = rdata >> (8 * idx);
            3'd1, 3'd5: sh = rdata >> (8 * ((idx / 2) * 2));
            3'd2, 3'd6: sh = rdata >> (8 * ((idx / 4) * 4));
            default:    sh = rdata;
         endcase
         case (f3)
            3'd0: memres = {{56{sh[7]}}, sh[7:0]};
            3'd1: memres = {{48{sh[15]}}, sh[15:0]};
            3'd2: memres = {{32{sh[31]}}, sh[31:0]};
            3'd3: memres = sh;
            3'd4: memres = {56'b0, sh[7:0]};
            3'd5: memres = {48'b0, sh[15:0]};
            3'd6: memres = {32'b0, sh[31:0]};
            default: memres = 0;
         endcase
      end
      data = (op == 7'h03) ? memres : (op == 7'h6F || op == 7'h67) ? npc :
             (op == 7'h73) ? old : alu;
      ld = v && ir[11:7] != 0 &&
           ((op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h1B, 7'h3B}) ||
            (op == 7'h73 && f3 != 0));
      kind = int'(f3) % 4;
      srcv = (f3 >= 4) ? 64'(ir[19:15]) : rs1v;
      st = v && op == 7'h73 && kind != 0 && (kind == 1 || ir[19:15] != 0);
      addr = ir[31:20];
      cdata = (kind == 1) ? srcv : (kind == 2) ? (old | srcv) : (old & ~srcv);
   endtask

   task automatic present(input logic [31:0] ir, input logic v, input logic [63:0] npc,
                          input logic [63:0] alu, input logic [63:0] rdata,
                          input logic [63:0] csrfd, input logic [63:0] rs1v);
      mem_ir = ir; mem_v = v; mem_npc = npc; mem_alu_result = alu;
      mem_rdata = rdata; mem_csrfd = csrfd; mem_rs1 = rs1v; ld_wb = 1'b1;
      @(posedge clk);
      #1 ld_wb = 1'b0;
   endtask

   typedef struct {
      logic [31:0] ir;
      logic [63:0] npc, alu, rdata, csrfd, rs1v, exp_data, exp_cdata;
      logic        exp_ld, exp_st;
   } vec_t;

   localparam logic [63:0] RD = 64'h8877665544332211;

   initial begin
      vec_t vt[13];
      logic [63:0] e_data, e_cdata, e_mem;
      logic [11:0] e_addr;
      logic        e_ld, e_st;
      logic [6:0]  ops[12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h1B,
                               7'h3B, 7'h73, 7'h23, 7'h63};
      vt[0]  = '{enc(7'h03, 3'd0, 5, 1, 0), 0, 64'h1003, RD, 0, 0, 64'h44, 0, 1, 0};
      vt[1]  = '{enc(7'h03, 3'd1, 5, 1, 0), 0, 64'h1006, RD, 0, 0, 64'hFFFFFFFFFFFF8877, 0, 1, 0};
      vt[2]  = '{enc(7'h03, 3'd2, 6, 1, 0), 0, 64'h1004, RD, 0, 0, 64'hFFFFFFFF88776655, 0, 1, 0};
      vt[3]  = '{enc(7'h03, 3'd4, 7, 1, 0), 0, 64'h1007, RD, 0, 0, 64'h88, 0, 1, 0};
      vt[4]  = '{enc(7'h03, 3'd3, 8, 1, 0), 0, 64'h1000, RD, 0, 0, RD, 0, 1, 0};
      vt[5]  = '{enc(7'h03, 3'd6, 9, 1, 0), 0, 64'h1005, RD, 0, 0, 64'h88776655, 0, 1, 0};
      vt[6]  = '{enc(7'h13, 3'd0, 0, 1, 5), 0, 64'h5, 0, 0, 0, 64'h5, 0, 0, 0};
      vt[7]  = '{enc(7'h13, 3'd0, 3, 0, 7), 0, 64'h7, 0, 0, 0, 64'h7, 0, 1, 0};
      vt[8]  = '{enc(7'h73, 3'd2, 4, 0, 12'h300), 0, 0, 0, 64'h55, 64'h99, 64'h55, 0, 1, 0};
      vt[9]  = '{enc(7'h73, 3'd3, 4, 2, 12'h300), 0, 0, 0, 64'hFF, 64'h0F, 64'hFF, 64'hF0, 1, 1};
      vt[10] = '{enc(7'h6F, 3'd0, 1, 0, 0), 64'h2004, 64'h9999, 0, 0, 0, 64'h2004, 0, 1, 0};
      vt[11] = '{enc(7'h73, 3'd5, 0, 5, 12'h340), 0, 0, 0, 64'h33, 64'hAA, 64'h33, 64'h5, 0, 1};
      vt[12] = '{enc(7'h23, 3'd3, 4, 2, 0), 0, 64'h1234, 0, 0, 0, 64'h1234, 0, 0, 0};

      #1;
      chk("rst_wb_v", 64'(wb_v), 0);
      chk("rst_data", wb_data, 0);
      chk("rst_ctl", {wb_ld_reg, wb_st_csr, wb_cs, wb_cause, wb_stall, wb_redirect}, 0);
      chk("rst_csr_data", wb_csr_data, 0);
      chk("rst_mem_result", wb_mem_result, 0);
      chk("rst_redirect_pc", wb_redirect_pc, 64'h8000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vt[i]) begin
         present(vt[i].ir, 1'b1, vt[i].npc, vt[i].alu, vt[i].rdata, vt[i].csrfd, vt[i].rs1v);
         chk($sformatf("vec%0d_data", i), wb_data, vt[i].exp_data);
         chk($sformatf("vec%0d_ld_reg", i), 64'(wb_ld_reg), 64'(vt[i].exp_ld));
         chk($sformatf("vec%0d_st_csr", i), 64'(wb_st_csr), 64'(vt[i].exp_st));
         if (vt[i].exp_st) chk($sformatf("vec%0d_csr_data", i), wb_csr_data, vt[i].exp_cdata);
      end

      for (int n = 0; n < 200; n++) begin
         logic [31:0] ir;
         logic [63:0] npc, alu, rdata, old, rs1v;
         logic        v;
         ir = $urandom;
         ir[6:0] = ops[$urandom_range(0, 11)];
         if (ir[6:0] == 7'h03 && ir[14:12] == 3'd7) ir[14:12] = 3'd3;
         if (ir[6:0] == 7'h73 && ir[14:12] == 3'd4) ir[14:12] = 3'd5;
         if (ir[6:0] == 7'h73 && ir[14:12] == 3'd0) ir = 32'h00100073;
         v = ($urandom_range(0, 7) != 0);
         npc = {$urandom, $urandom}; alu = {$urandom, $urandom}; rdata = {$urandom, $urandom};
         old = {$urandom, $urandom}; rs1v = {$urandom, $urandom};
         present(ir, v, npc, alu, rdata, old, rs1v);
         model(ir, v, npc, alu, rdata, old, rs1v, e_data, e_ld, e_st, e_addr, e_cdata, e_mem);
         chk($sformatf("rnd%0d_data", n), wb_data, e_data);
         chk($sformatf("rnd%0d_mem", n), wb_mem_result, e_mem);
         chk($sformatf("rnd%0d_we", n), {wb_v, wb_ld_reg, wb_st_csr, wb_stall}, {v, e_ld, e_st, 1'b0});
         if (e_st) begin
            chk($sformatf("rnd%0d_csr_addr", n), 64'(wb_csr_addr), 64'(e_addr));
            chk($sformatf("rnd%0d_csr_data", n), wb_csr_data, e_cdata);
         end
      end

      // ECALL: N stall, N+1 mepc, N+2 mcause, N+3 redirect, N+4 killed follower
      present(32'h73, 1'b1, 64'h1004, 0, 0, 0, 0);
      chk("ecall_n_ctl", {wb_stall, wb_cs, wb_st_csr, wb_ld_reg, wb_redirect}, 5'b10000);
      mem_ir = enc(7'h13, 3'd0, 3, 0, 7); mem_v = 1'b1; mem_alu_result = 64'h7; ld_wb = 1'b1;
      @(posedge clk); #1;
      chk("ecall_n1_ctl", {wb_stall, wb_cs, wb_st_csr, wb_cause, wb_redirect, wb_ld_reg}, 6'b111000);
      chk("ecall_mepc_addr", 64'(wb_csr_addr), 64'h341);
      chk("ecall_mepc_data", wb_csr_data, 64'h1000);
      @(posedge clk); #1;
      chk("ecall_n2_ctl", {wb_stall, wb_cs, wb_st_csr, wb_cause, wb_redirect}, 5'b11110);
      chk("ecall_mcause_addr", 64'(wb_csr_addr), 64'h342);
      chk("ecall_mcause_data", wb_csr_data, 64'd11);
      @(posedge clk); #1;
      chk("ecall_n3_ctl", {wb_stall, wb_cs, wb_st_csr, wb_cause, wb_redirect}, 5'b01001);
      chk("ecall_redirect_pc", wb_redirect_pc, 64'h8000);
      chk("ecall_n3_ir", 64'(wb_ir), 64'h73);
      @(posedge clk); #1;
      chk("ecall_n4_ctl", {wb_v, wb_cs, wb_redirect, wb_stall, wb_ld_reg}, 0);
      @(posedge clk); #1 ld_wb = 1'b0;
      chk("ecall_n5_follower", {wb_v, wb_ld_reg}, 2'b11);
      chk("ecall_n5_data", wb_data, 64'h7);

      // reset asserted while mcause is being written
      present(32'h73, 1'b1, 64'h3004, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 chk("mid_cause_seen", 64'(wb_cause), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ctl", {wb_v, wb_ld_reg, wb_st_csr, wb_cs, wb_cause, wb_stall, wb_redirect}, 0);
      chk("mid_rst_data", wb_data, 0);
      chk("mid_rst_csr_data", wb_csr_data, 0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("mid_rst_redirect%0d", c), 64'(wb_redirect), 0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst_idle%0d", c), {wb_redirect, wb_cs, wb_stall}, 0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
